// File: rtl/ring_router_demux_n.sv
// ring_router_demux_n: routes whole worms from one input channel to one of
// NLOCAL local ports or the ring port. The first flit's destination ID picks
// the port, and the rest of the worm follows that port. With REG_OUT=1, each
// port gets a 2-entry skid buffer so that every output comes from a register.
module ring_router_demux_n #(
  parameter int WIDTH    = 16,
  parameter int ID_WIDTH = 10,
  parameter int NLOCAL   = 2,
  parameter int REG_OUT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NLOCAL*ID_WIDTH-1:0] local_ids,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NLOCAL*WIDTH-1:0]    local_data,
  output logic [NLOCAL-1:0]          local_first,
  output logic [NLOCAL-1:0]          local_last,
  output logic [NLOCAL-1:0]          local_valid,
  input  logic [NLOCAL-1:0]          local_ready,
  output logic [WIDTH-1:0]           ring_data,
  output logic                       ring_first,
  output logic                       ring_last,
  output logic                       ring_valid,
  input  logic                       ring_ready
);

  // Port index NLOCAL is the ring port; indices below it are local ports.
  localparam int NP    = NLOCAL + 1;
  localparam int SEL_W = $clog2(NP);
  localparam int FW    = WIDTH + 2;

  typedef enum logic {S_IDLE, S_WORM} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] dec_route;
  logic [SEL_W-1:0] cur_route;
  logic [NP-1:0]    route_oh;
  logic [NP-1:0]    port_ready;
  logic [NP-1:0]    out_valid;
  logic [NP-1:0]    out_first;
  logic [NP-1:0]    out_last;
  logic [WIDTH-1:0] out_data [NP];
  logic             accept;

  // Destination decode: the lowest matching local port wins, and no match means ring.
  always_comb begin
    dec_route = SEL_W'(NLOCAL);
    for (int k = NLOCAL - 1; k >= 0; k--) begin
      if (in_data[ID_WIDTH-1:0] == local_ids[k*ID_WIDTH +: ID_WIDTH])
        dec_route = SEL_W'(k);
    end
  end

  // Mid-worm, the latched route is used and the decode (including in_first) is ignored.
  assign cur_route  = (state == S_WORM) ? sel : dec_route;
  assign port_ready = {ring_ready, local_ready};
  assign accept     = in_valid & in_ready;

  // One-hot form of the current route.
  always_comb begin
    route_oh = '0;
    for (int p = 0; p < NP; p++)
      route_oh[p] = (cur_route == SEL_W'(p));
  end

  // Worm state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Worm next state: a multi-flit packet opens a worm, and its last flit closes it.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && !in_last) state_nx = S_WORM;
      S_WORM:  if (accept && in_last)  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Latch the decoded route when a worm opens. local_ids changes mid-worm have no effect.
  always_ff @(posedge clk) begin
    if (rst)
      sel <= SEL_W'(NLOCAL);
    else if (state == S_IDLE && accept && !in_last)
      sel <= dec_route;
  end

  generate
    if (REG_OUT == 0) begin : g_comb
      // ---- combinational output path: the input fans out and only the routed port is valid
      assign in_ready  = |(route_oh & port_ready);
      assign out_valid = route_oh & {NP{in_valid}};
      assign out_first = {NP{in_first}};
      assign out_last  = {NP{in_last}};
      for (genvar p = 0; p < NP; p++) begin : g_fan
        assign out_data[p] = in_data;
      end
    end else begin : g_reg
      // ---- registered output stage: main + skid entry per port
      logic [NP-1:0] main_v, skid_v, push, pop, load_main, load_skid;
      logic [FW-1:0] main_q [NP];
      logic [FW-1:0] skid_q [NP];

      assign push      = route_oh & {NP{accept}};
      assign pop       = main_v & port_ready;
      // An empty main entry (or one that is draining with no skid entry behind it) takes the new flit.
      assign load_main = push & (~main_v | (pop & ~skid_v));
      assign load_skid = push & main_v & (~pop | skid_v);
      // in_ready comes from registers only: it drops once any port holds two flits.
      assign in_ready  = &(~(main_v & skid_v));

      // Occupancy flags: a push and a pop in the same cycle keep occupancy the same.
      always_ff @(posedge clk) begin
        if (rst) begin
          main_v <= '0;
          skid_v <= '0;
        end else begin
          main_v <= (main_v & ~pop) | (pop & skid_v) | load_main;
          skid_v <= (skid_v & ~pop) | load_skid;
        end
      end

      // Flit storage. Data is left out of reset, so idle ports keep the last flit they held.
      always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
          if (load_main[p])
            main_q[p] <= {in_first, in_last, in_data};
          else if (pop[p] && skid_v[p])
            main_q[p] <= skid_q[p];
          if (load_skid[p])
            skid_q[p] <= {in_first, in_last, in_data};
        end
      end

      assign out_valid = main_v;
      for (genvar p = 0; p < NP; p++) begin : g_out
        assign out_data[p]  = main_q[p][WIDTH-1:0];
        assign out_first[p] = main_q[p][WIDTH+1];
        assign out_last[p]  = main_q[p][WIDTH];
      end
    end
  endgenerate

  // ---- port unpacking
  for (genvar k = 0; k < NLOCAL; k++) begin : g_local
    assign local_data[k*WIDTH +: WIDTH] = out_data[k];
    assign local_first[k]               = out_first[k];
    assign local_last[k]                = out_last[k];
    assign local_valid[k]               = out_valid[k];
  end

  assign ring_data  = out_data[NLOCAL];
  assign ring_first = out_first[NLOCAL];
  assign ring_last  = out_last[NLOCAL];
  assign ring_valid = out_valid[NLOCAL];

endmodule

// File: tb/tb_ring_router_demux_n.sv
// Testbench for ring_router_demux_n. It uses a combinational instance (REG_OUT=0)
// driven from a vector table, and a registered instance (REG_OUT=1) driven by
// hand-written streaming and reset sequences.
module tb_ring_router_demux_n;
  localparam int W  = 16;
  localparam int IW = 10;
  localparam int NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [NL*IW-1:0] ids0, ids1;
  logic [W-1:0]     d0, d1;
  logic             f0, l0, v0, f1, l1, v1;
  logic             rdy0, rdy1;
  logic [NL*W-1:0]  ld0, ld1;
  logic [NL-1:0]    lf0, ll0, lv0, lr0, lf1, ll1, lv1, lr1;
  logic [W-1:0]     rd0, rd1;
  logic             rf0, rl0, rv0, rr0, rf1, rl1, rv1, rr1;

  ring_router_demux_n #(.WIDTH(W), .ID_WIDTH(IW), .NLOCAL(NL), .REG_OUT(0)) u0 (
    .clk(clk), .rst(rst), .local_ids(ids0),
    .in_data(d0), .in_first(f0), .in_last(l0), .in_valid(v0), .in_ready(rdy0),
    .local_data(ld0), .local_first(lf0), .local_last(ll0), .local_valid(lv0), .local_ready(lr0),
    .ring_data(rd0), .ring_first(rf0), .ring_last(rl0), .ring_valid(rv0), .ring_ready(rr0)
  );

  ring_router_demux_n #(.WIDTH(W), .ID_WIDTH(IW), .NLOCAL(NL), .REG_OUT(1)) u1 (
    .clk(clk), .rst(rst), .local_ids(ids1),
    .in_data(d1), .in_first(f1), .in_last(l1), .in_valid(v1), .in_ready(rdy1),
    .local_data(ld1), .local_first(lf1), .local_last(ll1), .local_valid(lv1), .local_ready(lr1),
    .ring_data(rd1), .ring_first(rf1), .ring_last(rl1), .ring_valid(rv1), .ring_ready(rr1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] ids;
    logic [15:0] d;
    logic        f, l, v;
    logic [1:0]  lr;
    logic        rr;
    logic [1:0]  elv;
    logic        erv;
    logic        erdy;
  } vec_t;

  function automatic vec_t mk(logic [19:0] ids, logic [15:0] d, logic f, logic l, logic v,
                              logic [1:0] lr, logic rr, logic [1:0] elv, logic erv, logic erdy);
    vec_t r;
    r.ids = ids; r.d = d; r.f = f; r.l = l; r.v = v;
    r.lr = lr; r.rr = rr; r.elv = elv; r.erv = erv; r.erdy = erdy;
    return r;
  endfunction

  localparam logic [19:0] IDS_A = {10'h005, 10'h003};
  localparam logic [19:0] IDS_B = {10'h007, 10'h007};
  localparam logic [19:0] IDS_C = {10'h003, 10'h005};

  vec_t tbl[18];
  logic [17:0] q[$];
  logic [17:0] exp_flit;
  int sent, got;
  logic exp_rdy [14];
  logic exp_v   [14];

  initial begin
    // 3-flit worm to port 0, followed by an idle check that the worm has cleared
    tbl[0]  = mk(IDS_A, 16'h0003, 1, 0, 1, 2'b11, 1, 2'b01, 0, 1);
    tbl[1]  = mk(IDS_A, 16'h1234, 0, 0, 1, 2'b11, 1, 2'b01, 0, 1);
    tbl[2]  = mk(IDS_A, 16'h0abc, 0, 1, 1, 2'b11, 1, 2'b01, 0, 1);
    tbl[3]  = mk(IDS_A, 16'h03ff, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0);
    // 4-flit ring worm with ring_ready 1,0,1,1,0,1
    tbl[4]  = mk(IDS_A, 16'h03ff, 1, 0, 1, 2'b00, 1, 2'b00, 1, 1);
    tbl[5]  = mk(IDS_A, 16'h0002, 0, 0, 1, 2'b00, 0, 2'b00, 1, 0);
    tbl[6]  = mk(IDS_A, 16'h0002, 0, 0, 1, 2'b00, 1, 2'b00, 1, 1);
    tbl[7]  = mk(IDS_A, 16'h0003, 0, 0, 1, 2'b00, 1, 2'b00, 1, 1);
    tbl[8]  = mk(IDS_A, 16'h0004, 0, 1, 1, 2'b00, 0, 2'b00, 1, 0);
    tbl[9]  = mk(IDS_A, 16'h0004, 0, 1, 1, 2'b00, 1, 2'b00, 1, 1);
    // duplicate IDs: the lowest port wins
    tbl[10] = mk(IDS_B, 16'h0007, 1, 1, 1, 2'b10, 1, 2'b01, 0, 0);
    tbl[11] = mk(IDS_B, 16'h0007, 1, 1, 1, 2'b11, 1, 2'b01, 0, 1);
    // worm to port 1; mid-worm first flag, matching data and an ID change are all ignored
    tbl[12] = mk(IDS_A, 16'h0005, 1, 0, 1, 2'b11, 1, 2'b10, 0, 1);
    tbl[13] = mk(IDS_A, 16'h0003, 1, 0, 1, 2'b01, 1, 2'b10, 0, 0);
    tbl[14] = mk(IDS_A, 16'h0003, 1, 0, 1, 2'b10, 1, 2'b10, 0, 1);
    tbl[15] = mk(IDS_C, 16'h0005, 0, 1, 1, 2'b11, 1, 2'b10, 0, 1);
    // new IDs take effect at packet start, even without in_first
    tbl[16] = mk(IDS_C, 16'h0005, 0, 1, 1, 2'b11, 1, 2'b01, 0, 1);
    tbl[17] = mk(IDS_A, 16'h0005, 1, 1, 0, 2'b01, 1, 2'b00, 0, 0);

    exp_rdy = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    exp_v   = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

    rst = 1'b1;
    ids0 = IDS_A; d0 = '0; f0 = 0; l0 = 0; v0 = 0; lr0 = '1; rr0 = 1;
    ids1 = IDS_C; d1 = '0; f1 = 0; l1 = 0; v1 = 0; lr1 = '1; rr1 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset lv0", {30'b0, lv0}, 0);
    check("reset rv0", {31'b0, rv0}, 0);
    check("reset lv1", {30'b0, lv1}, 0);
    check("reset rv1", {31'b0, rv1}, 0);
    check("reset rdy1", {31'b0, rdy1}, 1);
    @(negedge clk);
    rst = 1'b0;

    // combinational instance: vector table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      ids0 = tbl[i].ids; d0 = tbl[i].d; f0 = tbl[i].f; l0 = tbl[i].l; v0 = tbl[i].v;
      lr0 = tbl[i].lr; rr0 = tbl[i].rr;
      #1;
      check($sformatf("vec%0d local_valid", i), {30'b0, lv0}, {30'b0, tbl[i].elv});
      check($sformatf("vec%0d ring_valid", i), {31'b0, rv0}, {31'b0, tbl[i].erv});
      check($sformatf("vec%0d in_ready", i), {31'b0, rdy0}, {31'b0, tbl[i].erdy});
      check($sformatf("vec%0d ring_data", i), {16'b0, rd0}, {16'b0, tbl[i].d});
      check($sformatf("vec%0d local_data", i), ld0, {tbl[i].d, tbl[i].d});
    end
    @(negedge clk);
    v0 = 0;

    // registered instance: 8-flit stream to port 1, ready low for 2 cycles
    sent = 0; got = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      lr1 = (c == 4 || c == 5) ? 2'b01 : 2'b11;
      if (sent < 8) begin
        v1 = 1;
        d1 = (sent == 0) ? 16'h0003 : 16'h0100 + 16'(sent);
        f1 = (sent == 0);
        l1 = (sent == 7);
      end else begin
        v1 = 0;
      end
      #1;
      check($sformatf("stream c%0d in_ready", c), {31'b0, rdy1}, {31'b0, exp_rdy[c]});
      check($sformatf("stream c%0d port1 valid", c), {31'b0, lv1[1]}, {31'b0, exp_v[c]});
      check($sformatf("stream c%0d other valids", c), {30'b0, lv1[0], rv1}, 0);
      if (lv1[1] && lr1[1]) begin
        if (q.size() == 0) begin
          check($sformatf("stream c%0d unexpected flit", c), {14'b0, lf1[1], ll1[1], ld1[31:16]}, 32'hffffffff);
        end else begin
          exp_flit = q.pop_front();
          check($sformatf("stream c%0d flit", c), {14'b0, lf1[1], ll1[1], ld1[31:16]}, {14'b0, exp_flit});
          got++;
        end
      end
      if (v1 && rdy1) begin
        q.push_back({f1, l1, d1});
        sent++;
      end
    end
    check("stream sent", sent, 8);
    check("stream received", got, 8);
    check("stream hold data", {16'b0, ld1[31:16]}, 32'h0107);

    // registered instance: reset after flit 2 of a 5-flit worm
    @(negedge clk);
    v1 = 1; d1 = 16'h0003; f1 = 1; l1 = 0; lr1 = 2'b11;
    @(negedge clk);
    d1 = 16'h0201; f1 = 0;
    @(negedge clk);
    v1 = 0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("midworm reset lv1", {30'b0, lv1}, 0);
    check("midworm reset rv1", {31'b0, rv1}, 0);
    check("midworm reset rdy1", {31'b0, rdy1}, 1);
    @(negedge clk);
    rst = 1'b0; v1 = 1; d1 = 16'h0005; f1 = 0; l1 = 0;
    @(posedge clk);
    #1;
    check("post reset route", {30'b0, lv1}, 32'h1);
    check("post reset data", {16'b0, ld1[15:0]}, 32'h0005);
    check("post reset ring", {31'b0, rv1}, 0);
    @(negedge clk);
    d1 = 16'h0777; l1 = 1;
    @(posedge clk);
    #1;
    check("post reset worm route", {30'b0, lv1}, 32'h1);
    check("post reset worm data", {16'b0, ld1[15:0]}, 32'h0777);
    check("post reset worm last", {31'b0, ll1[0]}, 1);
    @(negedge clk);
    v1 = 0;
    @(posedge clk);
    #1;
    check("drained lv1", {30'b0, lv1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_router_demux_n.md
Name: ring_router_demux_n

Overview:
- Parametrised packet demultiplexer for the debug interconnect ring router.
- Routes whole worms (first..last flit) from one input channel to one of NLOCAL local outputs or the single ring output, selected by the destination ID in the first flit.
- Optionally adds a full-throughput registered output stage (skid buffer) so router timing paths can be cut.

Parameters:
- WIDTH, 16, flit data width in bits.
- ID_WIDTH, 10, destination ID field width; field is data[ID_WIDTH-1:0] of the first flit.
- NLOCAL, 2, number of local output ports (1..8).
- REG_OUT, 0, 0 = combinational path (zero latency); 1 = registered output, 2-entry skid buffer.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- local_ids  in  NLOCAL*ID_WIDTH  ID of local port k in slice [k*ID_WIDTH +: ID_WIDTH]; quasi-static
- in_data  in  WIDTH  input flit data
- in_first  in  1  first flit of packet
- in_last  in  1  last flit of packet
- in_valid  in  1  input flit valid
- in_ready  out  1  input accepted when in_valid & in_ready
- local_data  out  NLOCAL*WIDTH  per-local-port data
- local_first  out  NLOCAL  per-port first
- local_last  out  NLOCAL  per-port last
- local_valid  out  NLOCAL  per-port valid
- local_ready  in  NLOCAL  per-port ready
- ring_data  out  WIDTH  ring output data
- ring_first, ring_last, ring_valid  out  1 each  ring output sideband
- ring_ready  in  1  ring output ready

Behaviour:
- Route decode (combinational, first flit only):
  - match[k] = (in_data[ID_WIDTH-1:0] == local_ids[k]).
  - Lowest k with match[k] set wins.
  - No match selects the ring port.
- Worm state: registers worm (1b) and sel (index 0..NLOCAL, NLOCAL = ring).
  - worm=0: current route = decoded route.
    - Accepted flit with !in_last: worm<=1, sel<=decoded route.
    - Accepted single-flit packet (first & last): worm stays 0.
  - worm=1: current route = sel; decode is ignored (in_first mid-worm is treated as data).
    - Accepted flit with in_last: worm<=0.
- Flit acceptance:
  - A flit at worm=0 is routed by decode whether or not in_first is set.
  - The hop counter is not checked.
- REG_OUT=0:
  - Data, first and last fan out to all ports.
  - Only the selected port sees valid = in_valid; all other valids are 0.
  - in_ready = ready of the selected port.
  - Zero latency; no combinational dependency of in_ready on in_valid.
- REG_OUT=1:
  - Each output has a 2-entry skid buffer (main + skid register), and outputs are driven only from registers.
  - in_ready = AND over the buffers that are not full (main empty or skid empty). The flit's destination buffer always has room when the flit is accepted.
  - Accepted flit appears on the selected port the next cycle.
  - Sustains 1 flit/cycle per port when downstream ready is held high.
  - Downstream ready deassert: the flit in flight lands in skid; in_ready drops the following cycle.
  - Order is preserved per port.
  - Flits of one worm never go to two ports.
- Reset (rst=1 at a clk edge):
  - worm<=0, sel<=NLOCAL, all buffers emptied.
  - All *_valid = 0, in_ready follows the reset-state formula (REG_OUT=1: 1).
  - Reset mid-worm truncates the worm: the next accepted flit is decoded as a new packet.
- Simultaneous events:
  - Accept of the last flit and a new first flit cannot occur in the same cycle (one input).
  - The decode for the next packet uses state after worm clears.
  - Buffer push and pop in the same cycle keep occupancy constant.
- local_ids changes are honoured only at packet start; a change mid-worm does not redirect the worm.
- Output data/first/last of non-valid ports: REG_OUT=0 mirrors the input; REG_OUT=1 holds the last value.

Test Plan:
- NLOCAL=2, local_ids={0x005,0x003}, REG_OUT=0: 3-flit packet dest 0x003 with all ready=1 -> local_valid[0] high 3 cycles, local_valid[1] and ring_valid stay 0, worm clears after the last flit.
- Dest 0x3FF (no match), 4-flit packet, ring_ready toggling 1,0,1,1,0,1 -> all 4 flits on ring in order; in_ready mirrors ring_ready; no local valid.
- Duplicate local_ids {0x007,0x007}, dest 0x007 -> routed to local port 0 only.
- Worm to port 1, then mid-packet the second flit's data[9:0]=local_ids[0] with in_first=1 -> still on port 1 until in_last.
- REG_OUT=1, 8-flit stream, ready high -> one flit/cycle, 1-cycle latency. Ready low for 2 cycles mid-stream -> in_ready low after 1 cycle, no flit lost or duplicated, order intact.
- rst asserted after flit 2 of a 5-flit worm -> all valids 0 next cycle, buffers empty. The next flit with data[9:0]=0x005 is routed to local port 0 as a new packet.
